// File: rtl/n_reg_wb_arbiter.sv
// n_reg_wb_arbiter: N-source register writeback arbiter with per-source FIFOs, round-robin/locked arbitration and a registered write port
// Ports:
//   clk_i, rst_n_i            clock (rising edge), asynchronous active-low reset
//   src_valid_i/src_ready_o   per-source push handshake (ready = FIFO not full)
//   src_addr_i/src_data_i     packed per-source address/data, source k at [k*W +: W]
//   lock_i, lock_src_i        restrict arbitration to one source index
//   en_w_reg_o, w_reg_addr_o, w_reg_data_o, grant_src_o   registered register-file write port
//   busy_o                    any FIFO non-empty or write in progress
// Optional (macro N_WB_FORWARD_EN): rd_addr_i, fwd_hit_o, fwd_data_o for same-cycle forwarding.
module n_reg_wb_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
  input  logic                      lock_i,
  input  logic [2:0]                lock_src_i,
  output logic                      en_w_reg_o,
  output logic [ADDR_W-1:0]         w_reg_addr_o,
  output logic [DATA_W-1:0]         w_reg_data_o,
  output logic [2:0]                grant_src_o,
  output logic                      busy_o
`ifdef N_WB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]         rd_addr_i,
  output logic                      fwd_hit_o,
  output logic [DATA_W-1:0]         fwd_data_o
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [PW:0] lp_one = 1;
  logic [EW-1:0] r_mem [NUM_SRC][FIFO_DEPTH];
  logic [PW:0] r_wp [NUM_SRC];
  logic [PW:0] r_rp [NUM_SRC];
  logic [2:0] r_rr;
  logic [NUM_SRC-1:0] w_full, w_empty, w_push, w_pop;
  logic w_gnt;
  logic [2:0] w_gidx;
  logic [EW-1:0] w_head;
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_comb begin
    w_full  = '0;
    w_empty = '0;
    w_push  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_empty[k] = r_wp[k] == r_rp[k];
      w_full[k]  = (r_wp[k][PW-1:0] == r_rp[k][PW-1:0]) && (r_wp[k][PW] != r_rp[k][PW]);
      w_push[k]  = src_valid_i[k] && !w_full[k];
    end
  end
  // Candidate order i=0..NUM_SRC-1 starts at the round-robin pointer; the first
  // non-empty one wins. When locked only lock_src_i can match, so an
  // out-of-range lock index never grants.
  always_comb begin
    w_gnt  = 1'b0;
    w_gidx = '0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = 0; k < NUM_SRC; k++)
        if (!w_gnt && !w_empty[k] && (lock_i ? (lock_src_i == 3'(k)) : (k == (int'(r_rr) + i) % NUM_SRC))) begin
          w_gnt  = 1'b1;
          w_gidx = 3'(k);
        end
  end
  always_comb begin
    w_pop  = '0;
    w_head = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (w_gnt && w_gidx == 3'(k)) begin
        w_pop[k] = 1'b1;
        w_head   = r_mem[k][r_rp[k][PW-1:0]];
      end
  end
  always_ff @(posedge clk_i)
    for (int k = 0; k < NUM_SRC; k++)
      if (w_push[k]) r_mem[k][r_wp[k][PW-1:0]] <= {src_addr_i[k*ADDR_W +: ADDR_W], src_data_i[k*DATA_W +: DATA_W]};
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        r_wp[k] <= '0;
        r_rp[k] <= '0;
      end
      r_rr         <= '0;
      en_w_reg_o   <= 1'b0;
      w_reg_addr_o <= '0;
      w_reg_data_o <= '0;
      grant_src_o  <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (w_push[k]) r_wp[k] <= r_wp[k] + lp_one;
        if (w_pop[k])  r_rp[k] <= r_rp[k] + lp_one;
      end
      if (w_gnt && !lock_i) r_rr <= (w_gidx == 3'(NUM_SRC - 1)) ? 3'd0 : w_gidx + 3'd1;
      en_w_reg_o <= w_gnt;
      if (w_gnt) begin
        {w_reg_addr_o, w_reg_data_o} <= w_head;
        grant_src_o                  <= w_gidx;
      end
    end
  assign src_ready_o = ~w_full;
  assign busy_o      = ~&w_empty | en_w_reg_o;
`ifdef N_WB_FORWARD_EN
  assign fwd_hit_o  = en_w_reg_o && (w_reg_addr_o == rd_addr_i);
  assign fwd_data_o = fwd_hit_o ? w_reg_data_o : '0;
`endif
endmodule

// File: tb/tb_n_reg_wb_arbiter.sv
// tb_n_reg_wb_arbiter: directed vector table plus hand sequences for lock, full/wrap, reset and forwarding
module tb_n_reg_wb_arbiter;
  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [1:0] src_valid_i = '0;
  logic [1:0] src_ready_o;
  logic [9:0] src_addr_i = '0;
  logic [15:0] src_data_i = '0;
  logic       lock_i = 1'b0;
  logic [2:0] lock_src_i = '0;
  logic       en_w_reg_o;
  logic [4:0] w_reg_addr_o;
  logic [7:0] w_reg_data_o;
  logic [2:0] grant_src_o;
  logic       busy_o;
`ifdef N_WB_FORWARD_EN
  logic [4:0] rd_addr_i = '0;
  logic       fwd_hit_o;
  logic [7:0] fwd_data_o;
`endif
  n_reg_wb_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_addr_i(src_addr_i), .src_data_i(src_data_i),
    .lock_i(lock_i), .lock_src_i(lock_src_i),
    .en_w_reg_o(en_w_reg_o), .w_reg_addr_o(w_reg_addr_o), .w_reg_data_o(w_reg_data_o),
    .grant_src_o(grant_src_o), .busy_o(busy_o)
`ifdef N_WB_FORWARD_EN
    , .rd_addr_i(rd_addr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic [1:0] v;
    logic [4:0] a0;
    logic [7:0] d0;
    logic [4:0] a1;
    logic [7:0] d1;
    logic       en;
    logic [4:0] addr;
    logic [7:0] data;
    logic [2:0] g;
    logic [1:0] rdy;
    logic       busy;
  } vec_t;
  vec_t vt[10];
  int n_cmp = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  function automatic logic [31:0] port;
    return {12'd0, en_w_reg_o, w_reg_addr_o, w_reg_data_o, grant_src_o};
  endfunction
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    logic acc;
    int n, wr;
    vt[0] = '{2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 3'd0, 2'b11, 1'b0};
    vt[1] = '{2'b01, 5'd5, 8'h3C, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 3'd0, 2'b11, 1'b1};
    vt[2] = '{2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b1, 5'd5, 8'h3C, 3'd0, 2'b11, 1'b1};
    vt[3] = '{2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 5'd5, 8'h3C, 3'd0, 2'b11, 1'b0};
    vt[4] = '{2'b11, 5'd1, 8'h10, 5'd2, 8'h20, 1'b0, 5'd5, 8'h3C, 3'd0, 2'b11, 1'b1};
    vt[5] = '{2'b11, 5'd1, 8'h11, 5'd2, 8'h21, 1'b1, 5'd2, 8'h20, 3'd1, 2'b11, 1'b1};
    vt[6] = '{2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b1, 5'd1, 8'h10, 3'd0, 2'b11, 1'b1};
    vt[7] = '{2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b1, 5'd2, 8'h21, 3'd1, 2'b11, 1'b1};
    vt[8] = '{2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b1, 5'd1, 8'h11, 3'd0, 2'b11, 1'b1};
    vt[9] = '{2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 5'd1, 8'h11, 3'd0, 2'b11, 1'b0};
    repeat (2) step;
    chk("reset_outputs", {port(), 3'd0, busy_o}, 32'd0);
    rst_n_i = 1'b1;
    #1;
    chk("reset_ready", {30'd0, src_ready_o}, 32'd3);
    for (int i = 0; i < 10; i++) begin
      src_valid_i = vt[i].v;
      src_addr_i  = {vt[i].a1, vt[i].a0};
      src_data_i  = {vt[i].d1, vt[i].d0};
      step;
      chk($sformatf("vec%0d", i), {port(), src_ready_o, busy_o},
          {12'd0, vt[i].en, vt[i].addr, vt[i].data, vt[i].g, vt[i].rdy, vt[i].busy});
    end
    src_valid_i = '0;
    lock_i = 1'b1;
    lock_src_i = 3'd0;
    for (int i = 0; i < 4; i++) begin
      src_valid_i = 2'b10;
      src_addr_i  = {5'(10 + i), 5'd0};
      src_data_i  = {8'(8'h40 + i), 8'h00};
      step;
    end
    chk("lock_full_ready", {30'd0, src_ready_o}, 32'd1);
    chk("lock_no_write", {31'd0, en_w_reg_o}, 32'd0);
    src_addr_i = {5'd14, 5'd0};
    src_data_i = {8'h44, 8'h00};
    step;
    chk("lock_5th_refused", {30'd0, src_ready_o}, 32'd1);
    src_valid_i = '0;
    lock_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk($sformatf("lock_release_wr%0d", i), port(), {12'd0, 1'b1, 5'(10 + i), 8'(8'h40 + i), 3'd1});
    end
    step;
    chk("lock_drained", {30'd0, en_w_reg_o, busy_o}, 32'd0);
    n = 0;
    wr = 0;
    lock_i = 1'b1;
    lock_src_i = 3'd1;
    for (int cyc = 0; cyc < 100 && wr < 16; cyc++) begin
      d = 8'(8'h80 + n);
      src_valid_i = {1'b0, n < 16};
      src_addr_i  = {5'd0, 5'(n)};
      src_data_i  = {8'h00, d};
      if (cyc == 6) begin
        lock_i = 1'b0;
        #1;
        chk("full_refuse", {31'd0, src_ready_o[0]}, 32'd0);
      end
      acc = src_valid_i[0] && src_ready_o[0];
      step;
      if (acc) begin
        q.push_back(d);
        n++;
      end
      if (cyc == 6) chk("push_after_pop", {31'd0, src_ready_o[0]}, 32'd1);
      if (en_w_reg_o) begin
        if (q.size() == 0) chk("stream_dup", 32'd1, 32'd0);
        else chk($sformatf("stream_wr%0d", wr), {24'd0, w_reg_data_o}, {24'd0, q.pop_front()});
        wr++;
      end
    end
    chk("stream_writes", 32'(wr), 32'd16);
    chk("stream_pushes", 32'(n), 32'd16);
    chk("stream_leftover", 32'(q.size()), 32'd0);
    src_valid_i = '0;
    step;
    chk("stream_idle", {30'd0, en_w_reg_o, busy_o}, 32'd0);
    lock_i = 1'b1;
    lock_src_i = 3'd5;
    src_valid_i = 2'b01;
    src_addr_i = {5'd0, 5'd3};
    src_data_i = {8'h00, 8'h77};
    step;
    src_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("bad_lock%0d", i), {30'd0, en_w_reg_o, busy_o}, 32'd1);
    end
    lock_i = 1'b0;
    step;
    chk("bad_lock_release", port(), {12'd0, 1'b1, 5'd3, 8'h77, 3'd0});
    lock_i = 1'b1;
    lock_src_i = 3'd1;
    for (int i = 0; i < 4; i++) begin
      src_valid_i = 2'b01;
      src_addr_i  = {5'd0, 5'(20 + i)};
      src_data_i  = {8'h00, 8'(8'hA0 + i)};
      step;
    end
    src_valid_i = '0;
    lock_i = 1'b0;
    step;
    chk("rst_pre_write", port(), {12'd0, 1'b1, 5'd20, 8'hA0, 3'd0});
    rst_n_i = 1'b0;
    #1;
    chk("rst_async", {port(), 3'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk($sformatf("rst_no_write%0d", i), {30'd0, en_w_reg_o, busy_o}, 32'd0);
    end
    chk("rst_ready", {30'd0, src_ready_o}, 32'd3);
`ifdef N_WB_FORWARD_EN
    src_valid_i = 2'b01;
    src_addr_i = {5'd0, 5'd7};
    src_data_i = {8'h00, 8'h5A};
    step;
    src_valid_i = '0;
    step;
    rd_addr_i = 5'd7;
    #1;
    chk("fwd_hit", {23'd0, fwd_hit_o, fwd_data_o}, {23'd0, 1'b1, 8'h5A});
    rd_addr_i = 5'd8;
    #1;
    chk("fwd_miss", {23'd0, fwd_hit_o, fwd_data_o}, 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
